// File: rtl/gray_pkg.sv
// Shared Gray-code helpers. The functions work at GRAY_MAX_WIDTH bits; narrower codes are
// zero-extended on the way in and truncated on the way out, which leaves both mappings exact.
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 32;

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero upper bits leave the lower result unchanged.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g);
    logic [GRAY_MAX_WIDTH-1:0] b;
    b = g;
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_conv.sv
// Combinational width-parametrised converter: binary->Gray and Gray->binary side by side.
module gray_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_in,
  output logic [WIDTH-1:0] gray_out,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] bin_out
);

  assign gray_out = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin_in)));
  assign bin_out  = WIDTH'(gray2bin(GRAY_MAX_WIDTH'(gray_in)));

endmodule

// File: rtl/gray_code_counter.sv
// Registered up/down Gray-code counter with binary/Gray load and wrap or saturate at the ends.
// Binary count and its Gray code are both flops, so gray_q is glitch-free for CDC use.
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             bound
);

  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic             SAT_EN = (SATURATE != 32'sd0);

  logic [WIDTH-1:0] ld_bin_s;
  logic [WIDTH-1:0] ld_gray_s;
  logic [WIDTH-1:0] cnt_bin_s;
  logic [WIDTH-1:0] cnt_gray_s;
  logic [WIDTH-1:0] conv_unused_bin_s;
  logic             cnt_bound_s;
  logic             at_max_s;
  logic             at_zero_s;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             bound_d;

  // Load path: decode a Gray load value and encode a binary one.
  gray_conv #(.WIDTH(WIDTH)) u_load_conv (
    .bin_in  (load_val),
    .gray_out(ld_gray_s),
    .gray_in (load_val),
    .bin_out (ld_bin_s)
  );

  // Next-state encode of the counted value; its decode half is not needed.
  gray_conv #(.WIDTH(WIDTH)) u_next_conv (
    .bin_in  (cnt_bin_s),
    .gray_out(cnt_gray_s),
    .gray_in ({WIDTH{1'b0}}),
    .bin_out (conv_unused_bin_s)
  );

  assign at_max_s  = &bin_q;
  assign at_zero_s = ~|bin_q;

  // Counting step and boundary detection (wrap pulse or blocked-step pulse).
  always_comb begin
    cnt_bin_s   = bin_q;
    cnt_bound_s = 1'b0;
    if (en) begin
      if (up) begin
        if (at_max_s && SAT_EN) begin
          cnt_bin_s   = bin_q;
          cnt_bound_s = 1'b1;
        end else begin
          cnt_bin_s   = bin_q + ONE;
          cnt_bound_s = at_max_s;
        end
      end else begin
        if (at_zero_s && SAT_EN) begin
          cnt_bin_s   = bin_q;
          cnt_bound_s = 1'b1;
        end else begin
          cnt_bin_s   = bin_q - ONE;
          cnt_bound_s = at_zero_s;
        end
      end
    end else begin
      cnt_bin_s   = bin_q;
      cnt_bound_s = 1'b0;
    end
  end

  // Next-state select: load wins over counting; a load never pulses bound.
  always_comb begin
    bin_d   = bin_q;
    gray_d  = gray_q;
    bound_d = 1'b0;
    if (load) begin
      if (load_gray) begin
        bin_d  = ld_bin_s;
        gray_d = load_val;
      end else begin
        bin_d  = load_val;
        gray_d = ld_gray_s;
      end
      bound_d = 1'b0;
    end else begin
      bin_d   = cnt_bin_s;
      gray_d  = cnt_gray_s;
      bound_d = cnt_bound_s;
    end
  end

  // Output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= {WIDTH{1'b0}};
      gray_q <= {WIDTH{1'b0}};
      bound  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      bound  <= bound_d;
    end
  end

endmodule

// File: tb/tb_gray_code_counter.sv
// Bench for gray_code_counter: a wrapping and a saturating instance driven by shared stimulus,
// checked against table constants, hand-written sequences and a small reference model.
module tb_gray_code_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, up, load, load_gray;
  logic [3:0] load_val;
  logic [3:0] bin_w, gray_w, bin_s, gray_s;
  logic       bound_w, bound_s;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic ld, lg, e, u;
    logic [3:0] v;
    logic [3:0] eb, eg;
    logic ebd;
  } vec_t;

  typedef struct {
    logic [3:0] bin, gray;
    logic bound;
    bit sat;
    string tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  logic [3:0] m_w, m_s;

  always #5 clk = ~clk;

  gray_code_counter #(.WIDTH(4), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .load_val(load_val), .bin_q(bin_w), .gray_q(gray_w), .bound(bound_w)
  );

  gray_code_counter #(.WIDTH(4), .SATURATE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_gray(load_gray),
    .load_val(load_val), .bin_q(bin_s), .gray_q(gray_s), .bound(bound_s)
  );

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b, expected %b", tag, act, exp);
    end
  endtask

  task automatic mnext(input logic [3:0] cur, input bit sat, input logic ld, lg, e, u,
                       input logic [3:0] v, output logic [3:0] nb, output logic nbd);
    nb = cur; nbd = 1'b0;
    if (ld) nb = lg ? g2b(v) : v;
    else if (e && u) begin
      if (cur == 4'hF) begin nb = sat ? cur : 4'h0; nbd = 1'b1; end
      else nb = cur + 4'd1;
    end else if (e) begin
      if (cur == 4'h0) begin nb = sat ? cur : 4'hF; nbd = 1'b1; end
      else nb = cur - 4'd1;
    end
  endtask

  // Drive one cycle of stimulus, queue expectations, then pop and compare after the edge.
  task automatic drive_step(input logic ld, lg, e, u, input logic [3:0] v, input bit use_tbl,
                            input logic [3:0] wb, wg, input logic wbd, input string tag);
    logic [3:0] nb;
    logic nbd;
    exp_t x;
    load = ld; load_gray = lg; en = e; up = u; load_val = v;
    mnext(m_w, 1'b0, ld, lg, e, u, v, nb, nbd);
    x.sat = 1'b0; x.tag = tag;
    if (use_tbl) begin x.bin = wb; x.gray = wg; x.bound = wbd; end
    else begin x.bin = nb; x.gray = b2g(nb); x.bound = nbd; end
    sb.push_back(x);
    m_w = x.bin;
    mnext(m_s, 1'b1, ld, lg, e, u, v, nb, nbd);
    x.sat = 1'b1; x.bin = nb; x.gray = b2g(nb); x.bound = nbd;
    sb.push_back(x);
    m_s = nb;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      if (x.sat) begin
        check({x.tag, "/s_bin"}, bin_s, x.bin);
        check({x.tag, "/s_gray"}, gray_s, x.gray);
        check({x.tag, "/s_bound"}, {3'b000, bound_s}, {3'b000, x.bound});
      end else begin
        check({x.tag, "/w_bin"}, bin_w, x.bin);
        check({x.tag, "/w_gray"}, gray_w, x.gray);
        check({x.tag, "/w_bound"}, {3'b000, bound_w}, {3'b000, x.bound});
      end
    end
  endtask

  task automatic add_vec(input logic ld, lg, e, u, input logic [3:0] v,
                         input logic [3:0] eb, eg, input logic ebd);
    vec_t t;
    t.ld = ld; t.lg = lg; t.e = e; t.u = u; t.v = v; t.eb = eb; t.eg = eg; t.ebd = ebd;
    vecs.push_back(t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] gseq [16];
    logic [3:0] prev;
    gseq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
             4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    for (int i = 1; i <= 16; i++) add_vec(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 4'(i), gseq[i-1], i == 16);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'b1111, 4'b1000, 1'b1);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'b1110, 4'b1001, 1'b0);
    add_vec(1'b1, 1'b1, 1'b0, 1'b0, 4'b1101, 4'b1001, 4'b1101, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, 4'b0110, 4'b0110, 4'b0101, 1'b0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111, 4'b1000, 1'b0);
    add_vec(1'b1, 1'b0, 1'b1, 1'b1, 4'b0011, 4'b0011, 4'b0010, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'b0011, 4'b0010, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0011, 4'b0010, 1'b0);

    rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_gray = 1'b0; load_val = 4'h0;
    m_w = 4'h0; m_s = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/w_bin", bin_w, 4'h0);
    check("reset/w_gray", gray_w, 4'h0);
    check("reset/w_bound", {3'b000, bound_w}, 4'h0);
    check("reset/s_bin", bin_s, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_step(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, "hold_a");
    drive_step(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, "hold_b");

    foreach (vecs[i]) begin
      prev = gray_w;
      drive_step(vecs[i].ld, vecs[i].lg, vecs[i].e, vecs[i].u, vecs[i].v, 1'b1,
                 vecs[i].eb, vecs[i].eg, vecs[i].ebd, $sformatf("vec%0d", i));
      if (vecs[i].e && !vecs[i].ld)
        check($sformatf("vec%0d/onebit", i), 4'($countones(gray_w ^ prev)), 4'd1);
    end

    // Saturation at the top, then release downwards.
    drive_step(1'b1, 1'b0, 1'b0, 1'b0, 4'b1110, 1'b0, 4'h0, 4'h0, 1'b0, "sat_load");
    for (int k = 0; k < 3; k++) begin
      drive_step(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, $sformatf("sat_up%0d", k));
      check($sformatf("sat_up%0d/bin", k), bin_s, 4'b1111);
      check($sformatf("sat_up%0d/bound", k), {3'b000, bound_s}, {3'b000, k != 0});
    end
    drive_step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, "sat_down");
    check("sat_down/bin", bin_s, 4'b1110);
    check("sat_down/bound", {3'b000, bound_s}, 4'h0);

    // Saturation at zero going down.
    drive_step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, "zero_load");
    for (int k = 0; k < 2; k++) begin
      drive_step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, $sformatf("zero_dn%0d", k));
      check($sformatf("zero_dn%0d/bin", k), bin_s, 4'h0);
      check($sformatf("zero_dn%0d/bound", k), {3'b000, bound_s}, 4'h1);
    end

    // Asynchronous reset in the middle of a count.
    drive_step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 4'h0, 4'h0, 1'b0, "mid_load");
    drive_step(1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 1'b1, 4'b0101, 4'b0111, 1'b0, "mid_step");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst/w_bin", bin_w, 4'h0);
    check("async_rst/w_gray", gray_w, 4'h0);
    check("async_rst/w_bound", {3'b000, bound_w}, 4'h0);
    check("async_rst/s_bin", bin_s, 4'h0);
    check("async_rst/s_gray", gray_s, 4'h0);
    en = 1'b0; up = 1'b0; load = 1'b0;
    m_w = 4'h0; m_s = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_step(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, "post_rst_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
